// File: rtl/puf_race_launcher.sv
// puf_race_launcher: drives a registered challenge and a shared launch edge
// into the two arbiter-PUF delay chains, repeats the race REPEAT times and
// returns a majority-voted response bit with a ones count and agreement flag.
module puf_race_launcher #(
    parameter int CHAL_W     = 64,
    parameter int SETTLE_CYC = 4,
    parameter int REPEAT     = 5,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [CHAL_W-1:0] challenge_in,
    output logic [CHAL_W-1:0] challenge_out,
    output logic              launch,
    input  logic              arb_q,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              response,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic              stable
);

    localparam int TW = $clog2(SETTLE_CYC + 2) + 1;
    localparam int RW = $clog2(REPEAT) + 1;

    localparam logic [TW-1:0]    SETUP_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]    FIRE_LAST  = TW'(SETTLE_CYC + 1);
    localparam logic [RW-1:0]    REP_LAST   = RW'(REPEAT - 1);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(REPEAT / 2);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(REPEAT);

    typedef enum logic [1:0] {IDLE, SETUP, FIRE, DONE} state_t;

    state_t              state_q, state_nxt;
    logic [TW-1:0]       timer_q, timer_nxt;
    logic [RW-1:0]       rep_q, rep_nxt;
    logic [CNT_W-1:0]    ones_q, ones_nxt, ones_sum;
    logic [CHAL_W-1:0]   chal_q, chal_nxt;
    logic                resp_q, resp_nxt;
    logic                stable_q, stable_nxt;
    logic                launch_q;
    logic                arb_p0, arb_s;

    // Two-flop synchronizer: arb_q is launched by the race, not by clk.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            arb_p0 <= 1'b0;
            arb_s  <= 1'b0;
        end else begin
            arb_p0 <= arb_q;
            arb_s  <= arb_p0;
        end
    end

    assign ones_sum = ones_q + CNT_W'(arb_s);

    // Next-state logic: phase timer, repeat index, ones accumulation and vote.
    always_comb begin
        state_nxt  = state_q;
        timer_nxt  = timer_q;
        rep_nxt    = rep_q;
        ones_nxt   = ones_q;
        chal_nxt   = chal_q;
        resp_nxt   = resp_q;
        stable_nxt = stable_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    chal_nxt  = challenge_in;
                    ones_nxt  = '0;
                    rep_nxt   = '0;
                    timer_nxt = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (timer_q == SETUP_LAST) begin
                    timer_nxt = '0;
                    state_nxt = FIRE;
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            FIRE: begin
                if (timer_q == FIRE_LAST) begin
                    timer_nxt = '0;
                    ones_nxt  = ones_sum;
                    rep_nxt   = rep_q + RW'(1);
                    if (rep_q == REP_LAST) begin
                        state_nxt  = DONE;
                        resp_nxt   = (ones_sum > HALF);
                        stable_nxt = (ones_sum == '0) || (ones_sum == FULL);
                    end else begin
                        state_nxt = SETUP;
                    end
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt  = IDLE;
                    resp_nxt   = 1'b0;
                    stable_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; launch is its own flop so it never glitches.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            rep_q    <= '0;
            ones_q   <= '0;
            chal_q   <= '0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            timer_q  <= timer_nxt;
            rep_q    <= rep_nxt;
            ones_q   <= ones_nxt;
            chal_q   <= chal_nxt;
            resp_q   <= resp_nxt;
            stable_q <= stable_nxt;
            launch_q <= (state_nxt == FIRE);
        end
    end

    assign start_ready   = (state_q == IDLE);
    assign resp_valid    = (state_q == DONE);
    assign challenge_out = chal_q;
    assign launch        = launch_q;
    assign response      = resp_q;
    assign ones_cnt      = ones_q;
    assign stable        = stable_q;

endmodule

// File: doc/puf_race_launcher.md
Name: puf_race_launcher

Overview:
- Transmit-side controller for the arbiter-PUF race. It drives the challenge bits and the shared launch edge into the two delay chains whose far ends feed the arbiter flop's clk/clr inputs.
- It then samples the arbiter output through a synchronizer and repeats the race REPEAT times. It returns a majority-voted response bit with a confidence count.
- Sits between the challenge source (valid/ready) and the mux-delay stages; one instance per PUF lane in the multi-PUF top.

Parameters:
- CHAL_W, 64, challenge width driven to the delay-stage select inputs.
- SETTLE_CYC, 4, clk cycles allowed for a race or a relax to propagate (>=1).
- REPEAT, 5, races per challenge; odd, >=1.
- CNT_W, 3, width of ones counter; must satisfy 2^CNT_W > REPEAT.

Ports:
- clk  input  1  system clock.
- clr  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion.
- start_valid  input  1  challenge request.
- start_ready  output  1  launcher idle and able to accept.
- challenge_in  input  CHAL_W  challenge presented with start_valid.
- challenge_out  output  CHAL_W  registered challenge to delay stages.
- launch  output  1  race launch edge into both chains (registered, glitch-free).
- arb_q  input  1  arbiter flop output; asynchronous to clk.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- response  output  1  majority vote.
- ones_cnt  output  CNT_W  number of races resolving to 1.
- stable  output  1  all REPEAT races agreed.

Behaviour:
- Reset values: start_ready=1, challenge_out=0, launch=0, resp_valid=0, response=0, ones_cnt=0, stable=0, synchronizer flops=0, FSM=IDLE.
- arb_q passes through a 2-flop synchronizer (arb_s) before any use.
- FSM states: IDLE, SETUP, FIRE, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready, capture challenge_in into challenge_out, clear ones counter and repeat index, go to SETUP.
- SETUP:
  - launch=0 for exactly SETTLE_CYC cycles, so both chains relax low.
  - Then go to FIRE.
- FIRE:
  - launch=1 for exactly SETTLE_CYC+2 cycles; the extra 2 cover the synchronizer.
  - On the last FIRE cycle, add arb_s to ones counter and increment repeat index.
  - If repeat index reaches REPEAT, go to DONE; else go to SETUP.
- DONE:
  - resp_valid=1; response=(ones_cnt > REPEAT/2); stable=(ones_cnt==0 || ones_cnt==REPEAT); launch=0.
  - Outputs are held constant until resp_valid&&resp_ready, then go to IDLE and drop resp_valid on that edge.
- Latency: resp_valid rises REPEAT*(2*SETTLE_CYC+2) cycles after the accept edge; 50 cycles at defaults.
- launch changes only in SETUP->FIRE, FIRE->SETUP and FIRE->DONE transitions. It never toggles within a state.
- start_ready=0 in SETUP, FIRE and DONE; start_valid is ignored there and is not queued.
- challenge_out stays stable from accept until the next accept; it does not change in DONE or IDLE.
- A new request may be accepted in the cycle after a DONE handshake. There is no zero-bubble overlap.
- ones counter saturates by construction and never exceeds REPEAT.
- clr mid-operation: launch drops to 0 asynchronously; any partial result is discarded and resp_valid=0; FSM=IDLE. After clr deassert, the next accept starts a full new sequence.
- REPEAT=1: single race; stable=1 always.

Test Plan:
- Reset then accept challenge 0xA5A5_0000_FFFF_1234 with arb_q tied 1 -> challenge_out matches; launch pattern 4 low/6 high x5; resp_valid at cycle 50; response=1, ones_cnt=5, stable=1.
- arb_q driven 1 during repeats 0,2,4 and 0 during 1,3 -> ones_cnt=3, response=1, stable=0; with 1 only during repeat 2 -> ones_cnt=1, response=0, stable=0.
- resp_ready held low 20 cycles after resp_valid -> response/ones_cnt/resp_valid held, start_ready=0, launch=0; handshake -> IDLE next cycle, start_ready=1.
- start_valid pulsed with a different challenge during FIRE -> ignored; challenge_out unchanged; exactly one result produced.
- clr asserted mid-cycle in FIRE of repeat 2 -> launch=0 and FIRE exit without waiting for clk; all outputs at reset values; a new request then yields the full 50-cycle result with ones_cnt from fresh races only.
- Change challenge_in every cycle after accept -> challenge_out constant through DONE.
